// File: rtl/thermal_cc_pkg.sv
// Shared definitions for the thermal covert channel (transmitter and sensor-side decoder).
// Holds the frame state enum, the preamble pattern and the frame field lengths.
package thermal_cc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_PARITY,
        ST_GUARD
    } tx_state_t;

    localparam logic [3:0]  PREAMBLE     = 4'b1010;
    localparam int unsigned PREAMBLE_LEN = 4;
    localparam int unsigned DATA_LEN     = 8;

    localparam int unsigned TIMER_W      = 32;
    localparam int unsigned SYM_CNT_W    = 8;

endpackage

// File: rtl/thermal_heater_bank.sv
// Bank of toggle flops used as a controllable on-die heat source.
// Ports: clk, rst (async active-high), en (toggle every cycle while high),
//        mon (MSB of the bank, keeps the bank observable so it is not optimised away).
module thermal_heater_bank #(
    parameter int unsigned HEATER_WIDTH = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mon
);

    // All flops start at 0 and toggle together, so every bit equals the MSB.
    (* keep = "true", dont_touch = "true" *) logic [HEATER_WIDTH-1:0] bank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
        end else if (en) begin
            bank_q <= ~bank_q;
        end
    end

    assign mon = bank_q[HEATER_WIDTH-1];

endmodule

// File: rtl/thermal_cc_tx.sv
// Transmit end of the temporal thermal covert channel.
// Accepts a byte on a valid/ready handshake and sends it as on-off-keyed heat:
// preamble 1010, data bits 7..0, even parity, then GUARD_BITS heater-off symbols.
// Ports: clk, rst (async active-high), tx_data/tx_valid/tx_ready (byte input handshake),
//        busy (frame in progress), heat_en (current symbol), sym_strobe (first cycle of
//        each symbol), heat_mon (heater bank MSB).
module thermal_cc_tx
    import thermal_cc_pkg::*;
#(
    parameter int unsigned BIT_PERIOD   = 134217728,
    parameter int unsigned HEATER_WIDTH = 1024,
    parameter int unsigned GUARD_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       heat_en,
    output logic       sym_strobe,
    output logic       heat_mon
);

    tx_state_t              state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [SYM_CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [DATA_LEN-1:0]    shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   heat_d, strobe_d, ready_d;
    logic                   sym_last;
    logic [1:0]             pre_idx;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            sym_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            heat_en    <= 1'b0;
            sym_strobe <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sym_cnt_q  <= sym_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            heat_en    <= heat_d;
            sym_strobe <= strobe_d;
            tx_ready   <= ready_d;
            busy       <= ~ready_d;
        end
    end

    // Next-state and next-output logic; heat_d is the value of the symbol about to start
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sym_cnt_d = sym_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        heat_d    = heat_en;
        strobe_d  = 1'b0;
        ready_d   = tx_ready;
        sym_last  = (timer_q == TIMER_W'(BIT_PERIOD - 1));
        // Preamble bit for the next symbol (sym_cnt_q + 1), sent MSB first
        pre_idx   = 2'd2 - sym_cnt_q[1:0];

        if (state_q == ST_IDLE) begin
            if (tx_valid) begin
                state_d   = ST_PREAMBLE;
                timer_d   = '0;
                sym_cnt_d = '0;
                shift_d   = tx_data;
                parity_d  = ^tx_data;
                heat_d    = PREAMBLE[PREAMBLE_LEN-1];
                strobe_d  = 1'b1;
                ready_d   = 1'b0;
            end
        end else begin
            timer_d = sym_last ? '0 : timer_q + TIMER_W'(1);
            if (sym_last) begin
                strobe_d = 1'b1;
                unique case (state_q)
                    ST_PREAMBLE: begin
                        if (sym_cnt_q == SYM_CNT_W'(PREAMBLE_LEN - 1)) begin
                            state_d   = ST_DATA;
                            sym_cnt_d = '0;
                            heat_d    = shift_q[DATA_LEN-1];
                        end else begin
                            sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
                            heat_d    = PREAMBLE[pre_idx];
                        end
                    end
                    ST_DATA: begin
                        shift_d = {shift_q[DATA_LEN-2:0], 1'b0};
                        if (sym_cnt_q == SYM_CNT_W'(DATA_LEN - 1)) begin
                            state_d   = ST_PARITY;
                            sym_cnt_d = '0;
                            heat_d    = parity_q;
                        end else begin
                            sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
                            heat_d    = shift_q[DATA_LEN-2];
                        end
                    end
                    ST_PARITY: begin
                        heat_d    = 1'b0;
                        sym_cnt_d = '0;
                        if (GUARD_BITS == 0) begin
                            state_d  = ST_IDLE;
                            strobe_d = 1'b0;
                            ready_d  = 1'b1;
                        end else begin
                            state_d = ST_GUARD;
                        end
                    end
                    ST_GUARD: begin
                        heat_d = 1'b0;
                        if (sym_cnt_q == SYM_CNT_W'(GUARD_BITS - 1)) begin
                            state_d   = ST_IDLE;
                            sym_cnt_d = '0;
                            strobe_d  = 1'b0;
                            ready_d   = 1'b1;
                        end else begin
                            sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        heat_d   = 1'b0;
                        strobe_d = 1'b0;
                        ready_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    thermal_heater_bank #(
        .HEATER_WIDTH(HEATER_WIDTH)
    ) u_heater_bank (
        .clk(clk),
        .rst(rst),
        .en (heat_en),
        .mon(heat_mon)
    );

endmodule

// File: tb/tb_thermal_cc_tx.sv
// Self-checking bench for thermal_cc_tx: directed scenarios plus random traffic,
// compared every cycle against a per-cycle expectation queue built from the frame format.
module tb_thermal_cc_tx;

    localparam int unsigned BP = 4;
    localparam int unsigned HW = 8;
    localparam int unsigned GB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, heat_en, sym_strobe, heat_mon;

    int total = 0;
    int bad   = 0;

    thermal_cc_tx #(
        .BIT_PERIOD  (BP),
        .HEATER_WIDTH(HW),
        .GUARD_BITS  (GB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .heat_en   (heat_en),
        .sym_strobe(sym_strobe),
        .heat_mon  (heat_mon)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: one queue entry per expected busy cycle
    typedef struct packed {
        logic heat;
        logic strobe;
    } cyc_t;

    cyc_t q[$];
    logic mon_m;

    function automatic void push_frame(input logic [7:0] b);
        logic bits[$];
        cyc_t c;
        bits = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
        bits.push_back(^b);
        for (int i = 0; i < int'(GB); i++) bits.push_back(1'b0);
        foreach (bits[s]) begin
            for (int k = 0; k < int'(BP); k++) begin
                c.heat   = bits[s];
                c.strobe = (k == 0);
                q.push_back(c);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mon_m = 1'b0;
        end else if (q.size() != 0) begin
            if (q[0].heat) mon_m = ~mon_m;
            void'(q.pop_front());
        end else if (tx_valid) begin
            push_frame(tx_data);
        end
    end

    // Per-cycle scoreboard, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() != 0) begin
                check("heat_en",    32'(heat_en),    32'(q[0].heat));
                check("sym_strobe", 32'(sym_strobe), 32'(q[0].strobe));
                check("tx_ready",   32'(tx_ready),   32'd0);
                check("busy",       32'(busy),       32'd1);
            end else begin
                check("heat_en",    32'(heat_en),    32'd0);
                check("sym_strobe", 32'(sym_strobe), 32'd0);
                check("tx_ready",   32'(tx_ready),   32'd1);
                check("busy",       32'(busy),       32'd0);
            end
            check("heat_mon", 32'(heat_mon), 32'(mon_m));
        end
    end

    task automatic send_one(input logic [7:0] b, input int wait_cyc);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        repeat (wait_cyc) @(negedge clk);
    endtask

    initial begin
        int n_strobe;
        int n_ready_cyc;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2;
        check("rst_ready",  32'(tx_ready),   32'd1);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_heat",   32'(heat_en),    32'd0);
        check("rst_strobe", 32'(sym_strobe), 32'd0);
        check("rst_mon",    32'(heat_mon),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 0xA5: count strobes and find when tx_ready returns
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        n_strobe = 0;
        n_ready_cyc = 0;
        for (int c = 1; c <= 70; c++) begin
            #1;
            if (sym_strobe) n_strobe++;
            if (tx_ready && n_ready_cyc == 0) n_ready_cyc = c;
            @(negedge clk);
        end
        check("a5_strobes", 32'(n_strobe), 32'd15);
        check("a5_ready_cycle", 32'(n_ready_cyc), 32'd61);

        send_one(8'h01, 66);

        // 0xFF held valid across the whole 0x3C frame
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_data  = 8'hFF;
        repeat (61) @(negedge clk);
        tx_valid = 1'b0;
        repeat (66) @(negedge clk);

        // Reset in the middle of the DATA state
        send_one(8'hC3, 24);
        #2 rst = 1'b1;
        #1;
        check("midrst_heat",  32'(heat_en),  32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_busy",  32'(busy),     32'd0);
        check("midrst_mon",   32'(heat_mon), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        send_one(8'h5A, 66);

        // Back-to-back 0x80 then 0x81
        tx_valid = 1'b1;
        tx_data  = 8'h80;
        @(negedge clk);
        tx_data  = 8'h81;
        repeat (61) @(negedge clk);
        tx_valid = 1'b0;
        repeat (66) @(negedge clk);

        // Random traffic with data changing every cycle
        for (int c = 0; c < 800; c++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (66) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thermal_cc_tx.md
# thermal_cc_tx

Transmit end of the temporal thermal covert channel. Accepts bytes over a valid/ready handshake and serialises each one as on-off-keyed heat. Each symbol enables or idles a bank of toggling flip-flops for a fixed number of clock cycles. The block sits beside the ring-oscillator counter sensor on the same die; that sensor recovers the bits from the frequency drift.

## Interface
- BIT_PERIOD, 134217728: clock cycles per symbol (≈1.07 s at 125 MHz); must be ≥ 2.
- HEATER_WIDTH, 1024: number of toggle flip-flops in the heater bank.
- GUARD_BITS, 2: heater-off symbols appended after each frame.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send, sampled on handshake.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block idle and able to accept a byte.
- busy  output  1  frame in progress (inverse of tx_ready).
- heat_en  output  1  current symbol value; 1 means the heater is toggling.
- sym_strobe  output  1  one-cycle pulse in the first cycle of every symbol.
- heat_mon  output  1  MSB of the heater bank; keeps the bank observable.

## Operation
- Frame, in send order: preamble 4'b1010, then data bits 7..0 (MSB first), then an even-parity bit (XOR of the 8 data bits), then GUARD_BITS zeros. With defaults this is 15 symbols.
- States: IDLE → PREAMBLE (4 symbols) → DATA (8) → PARITY (1) → GUARD (GUARD_BITS; skipped if 0) → IDLE.
- IDLE: tx_ready=1, heat_en=0. The handshake is tx_valid & tx_ready at a posedge. On handshake, latch tx_data into the shift register, load the symbol timer, and enter PREAMBLE.
- A 32-bit symbol timer counts 0..BIT_PERIOD-1. At wrap, advance the symbol index and state. A symbol counter indexes the preamble and guard bits; the shift register shifts left per data symbol.
- Heater bank: while heat_en=1, every flop inverts each cycle. While heat_en=0, the bank holds. Bank flops carry a synthesis keep/dont_touch attribute.
- tx_valid outside IDLE is ignored. tx_data does not need to stay stable after the handshake.
- Reset values: state IDLE, tx_ready=1, busy=0, heat_en=0, sym_strobe=0, heat_mon=0, heater bank all 0, timer 0.
- Reset asserted mid-frame clears everything immediately (asynchronously). The frame is abandoned; there is no resume.

## Timing
- Handshake at edge N: heat_en = first preamble bit (1) and sym_strobe=1 from edge N+1.
- Each symbol holds heat_en for exactly BIT_PERIOD cycles. sym_strobe pulses in the first cycle of each symbol.
- Frame duration is (13+GUARD_BITS)·BIT_PERIOD cycles, counted from edge N+1. On the last guard cycle's closing edge, the state returns to IDLE and tx_ready rises.
- Back-to-back bytes: a new handshake is possible in the first IDLE cycle. The minimum gap between frames is 1 cycle of heat_en=0 beyond the guard bits.
- heat_mon is registered and toggles each cycle that heat_en=1, with 0 cycles of added latency relative to the bank.

## Structure
- Package thermal_cc_pkg holds:
  - the state enum (IDLE, PREAMBLE, DATA, PARITY, GUARD);
  - localparam PREAMBLE = 4'b1010 and PREAMBLE_LEN = 4;
  - DATA_LEN = 8.
- The sensor-side decoder shares this package.
- Sub-module thermal_heater_bank (param HEATER_WIDTH; ports clk, rst, en, mon) contains the toggle flops and the keep attributes.
- The top level holds the FSM, symbol timer, shift register and parity.

## Test plan
All scenarios use BIT_PERIOD=4, HEATER_WIDTH=8, GUARD_BITS=2.
- Reset, then idle: tx_ready=1, busy=0, heat_en=0, and heat_mon constant for 20 cycles.
- Send 0xA5 → heat_en symbol sequence 1,0,1,0, 1,0,1,0,0,1,0,1, 0 (parity), 0,0. Each symbol lasts 4 cycles, giving 60 cycles total. sym_strobe gives 15 pulses. tx_ready returns to 1 at cycle 61.
- Send 0x01 → parity symbol = 1. heat_en is high in symbols 12 and 13 (cycles 45–52). heat_mon toggles in each of those 8 cycles.
- Assert tx_valid with 0xFF throughout a 0x3C frame → 0xFF is accepted only in the first IDLE cycle after the frame. The 0x3C waveform is unaffected.
- Assert rst during the DATA state (cycle 25) → heat_en=0 and tx_ready=1 immediately. The bank clears. After release, a new 0x5A frame transmits correctly from the preamble.
- Assert tx_valid continuously with 0x80, 0x81 → the two frames are separated by exactly 1 IDLE cycle. Both frames are bit-exact, with parity symbols 1 and 0.
